pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Generic, parametrised inter-stage pipeline register for the MIPS pipeline. It replaces the fixed per-stage registers (IF/ID … MEM/WB) with one block that has payload/control widths, valid/ready handshake, a 2-entry skid buffer, flush-to-bubble and sticky halt propagation. It sits between any two pipeline stages and is gated by the debug-unit step enable.

Parameters:
NB_DATA, 64, payload width (data fields: ALU result, memory data, etc.), bits
NB_CTRL, 8, control-field width (reg_write, mem_to_reg, reg address, …), bits
CLEAR_DATA_ON_FLUSH, 1, 1 = zero payload on flush; 0 = payload left unchanged, only valid/ctrl cleared

Ports:
i_clk  in  1  clock; all state updates on falling edge
i_reset  in  1  synchronous, active-high reset
i_step  in  1  debug step enable; 0 freezes all state
i_flush  in  1  hazard-unit flush; squashes stored entries
i_valid  in  1  upstream entry valid
o_ready  out  1  registered; block can accept an entry
i_ctrl  in  NB_CTRL  upstream control fields
i_data  in  NB_DATA  upstream payload
i_halt  in  1  upstream entry is a HALT instruction
o_valid  out  1  head entry valid
i_ready  in  1  downstream accepts head
o_ctrl  out  NB_CTRL  head control; forced 0 when o_valid=0
o_data  out  NB_DATA  head payload
o_halt  out  1  sticky: a HALT entry has been delivered
o_occupancy  out  2  stored entries, 0..2

Behaviour:
- Storage: head register (drives outputs), skid register. State EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
- push = i_valid & o_ready & i_step; pop = o_valid & i_ready & i_step.
- Priority on each falling edge: i_reset > (i_step=0: hold everything) > i_flush > push/pop.
- Reset: occ 0, o_valid 0, o_ready 1, o_ctrl 0, o_data 0, o_halt 0, skid cleared, halt_seen 0.
- Flush (with i_step=1): occ → 0, o_valid 0, o_ctrl 0. o_data and skid payload zeroed iff CLEAR_DATA_ON_FLUSH. Same-cycle push is dropped. o_halt and halt_seen are not cleared.
- EMPTY: push → ONE, head ← input. Latency input→output is 1 edge.
- ONE: push & pop → ONE, head ← input. push only → FULL, skid ← input. pop only → EMPTY.
- FULL: o_ready=0, so no push. pop → ONE, head ← skid.
- o_ready is registered. Next value = (next occ < 2) & !halt_seen. It never depends combinationally on i_ready.
- halt_seen is set when a push carries i_halt=1. Afterwards o_ready stays 0 until reset, so no instruction behind HALT enters.
- o_halt is set on the edge where a head entry with halt=1 is popped. It is sticky until reset. Held halt flag is stored per entry alongside ctrl.
- Ordering is strictly FIFO. No entry is duplicated or lost except by flush.
- i_step=0 mid-operation: all state frozen, and outputs hold their values.
- Reset mid-operation: all entries are discarded the same edge.

Decomposition:
- Shared package pipe_pkg: state encoding (EMPTY/ONE/FULL), occupancy constants, default widths per stage (IF_ID, ID_EX, EX_MEM, MEM_WB NB_DATA/NB_CTRL).
- One natural sub-module: pipe_entry_reg, a single {halt, ctrl, data} register with load and clear. It is instantiated twice, for head and skid.

Test Plan:
- Reset, then one entry with ctrl=8'hA5, data=64'h1234, i_ready=1, step=1 → o_valid=1 and o_ctrl=8'hA5 one edge later; occ=1, then 0 after pop.
- i_ready=0, push 3 back-to-back entries (data 1,2,3) → occ=2, o_ready=0 after 2nd, 3rd not accepted. Release i_ready → outputs 1 then 2, in order.
- Occ=2, i_flush=1 with i_valid=1 → occ=0, o_valid=0, o_ctrl=0, o_data=0 (CLEAR_DATA_ON_FLUSH=1). Incoming entry dropped.
- Occ=1, i_step=0 for 5 cycles while toggling i_valid/i_ready/i_flush → no change to any output.
- Push entry with i_halt=1, then data=7 → o_ready=0 after HALT, 7 not accepted. o_halt=1 after HALT popped, and it stays 1 across flush; cleared only by i_reset.
- Occ=1 with push & pop same edge, data 9 → 10 → o_data=10, occ stays 1. Reset asserted next edge → all outputs at reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy state
// encoding and the payload/control widths used by each MIPS stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int IF_ID_NB_DATA  = 64;
  localparam int IF_ID_NB_CTRL  = 8;
  localparam int ID_EX_NB_DATA  = 96;
  localparam int ID_EX_NB_CTRL  = 16;
  localparam int EX_MEM_NB_DATA = 64;
  localparam int EX_MEM_NB_CTRL = 12;
  localparam int MEM_WB_NB_DATA = 64;
  localparam int MEM_WB_NB_CTRL = 8;

  function automatic logic [1:0] occ_count(input occ_state_e st);
    case (st)
      ST_ONE:  return OCC_ONE;
      ST_FULL: return OCC_FULL;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_entry.sv
// One stored pipeline entry {halt, ctrl, data} with load and clear.
// Clear always drops halt/ctrl; payload is zeroed only when CLEAR_DATA is set.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int NB_DATA    = 64,
  parameter int NB_CTRL    = 8,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic               i_halt,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_halt,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_data
);

  logic               halt_q;
  logic [NB_CTRL-1:0] ctrl_q;
  logic [NB_DATA-1:0] data_q;

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      halt_q <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else if (i_clear) begin
      halt_q <= 1'b0;
      ctrl_q <= '0;
      if (CLEAR_DATA) data_q <= '0;
    end else if (i_load) begin
      halt_q <= i_halt;
      ctrl_q <= i_ctrl;
      data_q <= i_data;
    end
  end

  assign o_halt = halt_q;
  assign o_ctrl = ctrl_q;
  assign o_data = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake over a
// head + skid pair, flush-to-bubble, debug step gating and sticky HALT.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int NB_DATA             = 64,
  parameter int NB_CTRL             = 8,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_halt,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_halt,
  output logic [1:0]         o_occupancy
);

  occ_state_e state_q, state_d;
  logic       ready_q, ready_d;
  logic       halt_seen_q, halt_seen_d;
  logic       halt_out_q, halt_out_d;

  logic push, pop;
  logic head_load, head_clear, head_src_skid;
  logic skid_load, skid_clear;

  logic               head_halt, skid_halt, head_in_halt;
  logic [NB_CTRL-1:0] head_ctrl, skid_ctrl, head_in_ctrl;
  logic [NB_DATA-1:0] head_data, skid_data, head_in_data;

  assign push = i_valid & ready_q & i_step;
  assign pop  = (state_q != ST_EMPTY) & i_ready & i_step;

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_EMPTY;
      ready_q     <= 1'b1;
      halt_seen_q <= 1'b0;
      halt_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      halt_seen_q <= halt_seen_d;
      halt_out_q  <= halt_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    halt_out_d  = halt_out_q;
    if (i_step) begin
      if (i_flush) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: if (push) state_d = ST_ONE;
          ST_ONE: begin
            if (push && !pop)      state_d = ST_FULL;
            else if (!push && pop) state_d = ST_EMPTY;
          end
          ST_FULL:  if (pop) state_d = ST_ONE;
          default:  state_d = ST_EMPTY;
        endcase
        if (push && i_halt)    halt_seen_d = 1'b1;
        if (pop && head_halt)  halt_out_d  = 1'b1;
      end
    end
    // Ready is a registered look-ahead so it never depends on i_ready
    ready_d = i_step ? ((state_d != ST_FULL) && !halt_seen_d) : ready_q;
  end

  always_comb begin
    head_load     = 1'b0;
    head_clear    = 1'b0;
    head_src_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (i_step) begin
      if (i_flush) begin
        head_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: head_load = push;
          ST_ONE: begin
            head_load = push & pop;
            skid_load = push & ~pop;
          end
          ST_FULL: begin
            head_load     = pop;
            head_src_skid = 1'b1;
          end
          default: ;
        endcase
      end
    end
    o_valid     = (state_q != ST_EMPTY);
    o_occupancy = occ_count(state_q);
    o_ready     = ready_q;
    o_halt      = halt_out_q;
    o_ctrl      = o_valid ? head_ctrl : '0;
    o_data      = head_data;
  end

  assign head_in_halt = head_src_skid ? skid_halt : i_halt;
  assign head_in_ctrl = head_src_skid ? skid_ctrl : i_ctrl;
  assign head_in_data = head_src_skid ? skid_data : i_data;

  pipe_entry_reg #(
    .NB_DATA    (NB_DATA),
    .NB_CTRL    (NB_CTRL),
    .CLEAR_DATA (CLEAR_DATA_ON_FLUSH)
  ) u_head (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (head_load),
    .i_clear (head_clear),
    .i_halt  (head_in_halt),
    .i_ctrl  (head_in_ctrl),
    .i_data  (head_in_data),
    .o_halt  (head_halt),
    .o_ctrl  (head_ctrl),
    .o_data  (head_data)
  );

  pipe_entry_reg #(
    .NB_DATA    (NB_DATA),
    .NB_CTRL    (NB_CTRL),
    .CLEAR_DATA (CLEAR_DATA_ON_FLUSH)
  ) u_skid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (skid_load),
    .i_clear (skid_clear),
    .i_halt  (i_halt),
    .i_ctrl  (i_ctrl),
    .i_data  (i_data),
    .o_halt  (skid_halt),
    .o_ctrl  (skid_ctrl),
    .o_data  (skid_data)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: state changes on the falling edge,
// inputs are driven and outputs sampled 1 time unit after each falling edge.
`timescale 1ns/1ps
module tb_pipe_stage_skid_reg;

  logic        clk = 1'b0;
  logic        rst, step, flush, valid_in, ready_in, halt_in;
  logic [7:0]  ctrl_in;
  logic [63:0] data_in;
  logic        ready_out, valid_out, halt_out;
  logic [7:0]  ctrl_out;
  logic [63:0] data_out;
  logic [1:0]  occ_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(
    .NB_DATA             (64),
    .NB_CTRL             (8),
    .CLEAR_DATA_ON_FLUSH (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_step      (step),
    .i_flush     (flush),
    .i_valid     (valid_in),
    .o_ready     (ready_out),
    .i_ctrl      (ctrl_in),
    .i_data      (data_in),
    .i_halt      (halt_in),
    .o_valid     (valid_out),
    .i_ready     (ready_in),
    .o_ctrl      (ctrl_out),
    .o_data      (data_out),
    .o_halt      (halt_out),
    .o_occupancy (occ_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] occ, input logic v,
                           input logic rdy, input logic [7:0] c, input logic [63:0] d,
                           input logic h);
    chk({tag, ".occ"},   64'(occ_out),   64'(occ));
    chk({tag, ".valid"}, 64'(valid_out), 64'(v));
    chk({tag, ".ready"}, 64'(ready_out), 64'(rdy));
    chk({tag, ".ctrl"},  64'(ctrl_out),  64'(c));
    chk({tag, ".data"},  data_out,       d);
    chk({tag, ".halt"},  64'(halt_out),  64'(h));
  endtask

  initial begin
    rst = 1'b1; step = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    halt_in = 1'b0; ctrl_in = '0; data_in = '0;
    #2;
    tick();
    rst = 1'b0;
    chk_state("reset", 2'd0, 1'b0, 1'b1, 8'h00, 64'h0, 1'b0);

    // single entry, one-edge latency then pop
    valid_in = 1'b1; ctrl_in = 8'hA5; data_in = 64'h1234; ready_in = 1'b1;
    tick();
    chk_state("single_in", 2'd1, 1'b1, 1'b1, 8'hA5, 64'h1234, 1'b0);
    valid_in = 1'b0;
    tick();
    chk("single_pop.occ",   64'(occ_out),   64'd0);
    chk("single_pop.valid", 64'(valid_out), 64'd0);
    chk("single_pop.ctrl",  64'(ctrl_out),  64'd0);

    // back-pressure: three pushes, third refused
    ready_in = 1'b0; valid_in = 1'b1; ctrl_in = 8'h01; data_in = 64'd1;
    tick();
    chk("bp1.occ", 64'(occ_out), 64'd1);
    chk("bp1.ready", 64'(ready_out), 64'd1);
    ctrl_in = 8'h02; data_in = 64'd2;
    tick();
    chk("bp2.occ", 64'(occ_out), 64'd2);
    chk("bp2.ready", 64'(ready_out), 64'd0);
    ctrl_in = 8'h03; data_in = 64'd3;
    tick();
    chk("bp3.occ", 64'(occ_out), 64'd2);
    chk("bp3.data", data_out, 64'd1);
    valid_in = 1'b0; ready_in = 1'b1;
    tick();
    chk_state("drain1", 2'd1, 1'b1, 1'b1, 8'h02, 64'd2, 1'b0);
    tick();
    chk("drain2.occ", 64'(occ_out), 64'd0);
    chk("drain2.valid", 64'(valid_out), 64'd0);

    // flush while full with a concurrent push
    ready_in = 1'b0; valid_in = 1'b1; ctrl_in = 8'h11; data_in = 64'h11;
    tick();
    ctrl_in = 8'h22; data_in = 64'h22;
    tick();
    chk("pre_flush.occ", 64'(occ_out), 64'd2);
    flush = 1'b1; ctrl_in = 8'h33; data_in = 64'h33;
    tick();
    chk_state("flush", 2'd0, 1'b0, 1'b1, 8'h00, 64'h0, 1'b0);
    flush = 1'b0; valid_in = 1'b0;
    tick();
    chk("post_flush.occ", 64'(occ_out), 64'd0);

    // step=0 freezes everything
    valid_in = 1'b1; ctrl_in = 8'h5A; data_in = 64'h44;
    tick();
    chk("pre_freeze.occ", 64'(occ_out), 64'd1);
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = i[0]; ready_in = ~i[0]; flush = i[1];
      ctrl_in = 8'(8'hC0 + i); data_in = 64'(100 + i);
      tick();
      chk_state($sformatf("freeze%0d", i), 2'd1, 1'b1, 1'b1, 8'h5A, 64'h44, 1'b0);
    end
    step = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    tick();
    chk("unfreeze_pop.occ", 64'(occ_out), 64'd0);

    // HALT blocks later entries; o_halt sticky across flush
    ready_in = 1'b0; valid_in = 1'b1; halt_in = 1'b1; ctrl_in = 8'h77; data_in = 64'h99;
    tick();
    chk("halt_in.occ", 64'(occ_out), 64'd1);
    chk("halt_in.ready", 64'(ready_out), 64'd0);
    chk("halt_in.ohalt", 64'(halt_out), 64'd0);
    halt_in = 1'b0; ctrl_in = 8'h07; data_in = 64'd7;
    tick();
    chk("after_halt.occ", 64'(occ_out), 64'd1);
    chk("after_halt.data", data_out, 64'h99);
    valid_in = 1'b0; ready_in = 1'b1;
    tick();
    chk_state("halt_pop", 2'd0, 1'b0, 1'b0, 8'h00, 64'h99, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("halt_flush.ohalt", 64'(halt_out), 64'd1);
    chk("halt_flush.ready", 64'(ready_out), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_state("halt_reset", 2'd0, 1'b0, 1'b1, 8'h00, 64'h0, 1'b0);

    // simultaneous push & pop, then reset mid-operation
    ready_in = 1'b0; valid_in = 1'b1; ctrl_in = 8'h09; data_in = 64'd9;
    tick();
    chk("pp_first.data", data_out, 64'd9);
    ready_in = 1'b1; ctrl_in = 8'h0A; data_in = 64'd10;
    tick();
    chk_state("pushpop", 2'd1, 1'b1, 1'b1, 8'h0A, 64'd10, 1'b0);
    rst = 1'b1; ctrl_in = 8'h0B; data_in = 64'd11;
    tick();
    rst = 1'b0; valid_in = 1'b0;
    chk_state("mid_reset", 2'd0, 1'b0, 1'b1, 8'h00, 64'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
